feature_map_collector: RTL
==========================

Name: feature_map_collector

Overview:
Sink at the far end of the conv/pooling stream. Accepts the per-kernel valid vector and per-lane data emitted by a conv layer. Stores each kernel's pooled pixels into an internal feature-map buffer. Once a full frame is in, it replays the buffer in kernel-major order over a valid/ready port for the next stage or the bench scoreboard.

Parameters:
BitSize, 4, pixel width (two's complement)
NumberOfK, 8, kernels (feature maps) produced by the upstream layer
ProcessingElements, 2, data lanes per cycle; NumberOfK must be a multiple of it
MapWidth, 2, pooled feature-map width; each map holds MapWidth*MapWidth pixels

Ports:
clk  in  1  clock, all logic on rising edge
res_n  in  1  reset, synchronous, active-high (codebase port name retained; asserted = 1)
in_valid  in  NumberOfK  bit k set = kernel k has a pixel this cycle
in_data  in  ProcessingElements*BitSize  lane l carries the pixel for the asserted kernel k with k % ProcessingElements == l
in_ready  out  1  high only in COLLECT
out_valid  out  1  readback word valid
out_data  out  BitSize  readback pixel
out_kernel  out  clog2(NumberOfK)  kernel index of out_data
out_pixel  out  clog2(MapWidth*MapWidth)  raster index of out_data within its map
out_ready  in  1  downstream accept
frame_done  out  1  one-cycle pulse when the last word is accepted
err  out  1  sticky protocol error, cleared only by reset

Behaviour:
- Reset (res_n=1 at an edge): state=COLLECT; in_ready=1; out_valid=0; out_data, out_kernel, out_pixel=0; frame_done=0; err=0; all per-kernel pixel counters=0. Buffer contents are don't-care. Reset mid-frame or mid-drain discards everything.
- COLLECT:
  - Each cycle, for every asserted in_valid[k], write in_data lane (k % ProcessingElements) to buf[k][cnt[k]], then cnt[k]++.
  - Input is ignored whenever in_ready=0.
  - If two asserted kernels share a lane in one cycle, set err and write only the lower-index kernel.
  - A pixel for kernel k with cnt[k]==MapWidth^2 sets err and is dropped.
  - When every cnt[k]==MapWidth^2 (evaluated after this cycle's writes), go to DRAIN next cycle; in_ready drops the same cycle as the transition.
- DRAIN:
  - Read pointer (kernel, pixel) starts at (0,0).
  - Registered buffer read, so out_valid rises 1 cycle after entering DRAIN.
  - out_* are held stable while out_valid=1 and out_ready=0.
  - On accept (out_valid & out_ready), advance pixel, wrapping into kernel++. The next word is valid the following cycle, giving 1 word/cycle throughput under continuous out_ready.
  - Accepting the word at (NumberOfK-1, MapWidth^2-1): pulse frame_done, clear out_valid and all cnt, return to COLLECT, and set in_ready=1 on the next cycle.
- Arithmetic: data is stored bit-exact; no sign extension or saturation except under the optional feature.

Optional Feature:
FEATURE_MAP_COLLECTOR_RELU_EN
- Defined: on write, a pixel with MSB=1 (negative) is stored as 0; non-negative pixels are stored unchanged.
- Undefined: raw bits are stored.
- err, counters and timing are identical in both builds.

Decomposition:
- Shared package fmc_pkg:
  - localparams PixPerMap = MapWidth*MapWidth, KIdxW, PixIdxW
  - typedef pixel_t = logic [BitSize-1:0]
  - enum state_t {COLLECT, DRAIN}
- One sub-module, fmc_buffer: a 1-write-port-per-lane, 1-read-port register array of NumberOfK*PixPerMap pixel_t with registered read. The top holds the FSM, counters, lane mapping and error logic.

Test Plan:
- Lockstep fill (default params): each cycle assert in_valid=8'b0000_0011, then 8'b0000_1100, and so on, with data 4'h7 and 4'h2 on lanes 0 and 1; 16 cycles. Then out_ready=1. Expect:
  - in_ready=0 the cycle after the 16th write
  - 32 consecutive words, kernel-major, kernel0 = 7,7,7,7 and kernel1 = 2,2,2,2
  - frame_done on the 32nd accept; in_ready=1 the next cycle
- Backpressure: toggle out_ready 1010… during drain. Expect out_data/out_kernel/out_pixel stable across every stalled cycle, with no word lost or duplicated (32 accepts total).
- Lane collision: in_valid=8'b0000_0101 (k0 and k2, both lane 0), lane0 data 4'hF. Expect err=1; only cnt[0] increments; kernel2 is later read back with 4 pixels supplied afterwards, not the 4'hF.
- Overflow: send a 5th pixel to kernel 3 before the other kernels finish. Expect err=1 and the pixel dropped; readback of kernel 3 shows only the first 4 pixels.
- Reset mid-drain: assert res_n=1 after 10 accepts. Expect out_valid=0, in_ready=1, err=0 the next cycle; a fresh frame then drains correctly from (0,0).
- RELU build: write 4'b1000 and 4'b0111. Expect readback 4'h0 and 4'h7; without the macro, expect 4'h8 and 4'h7.

Source files
------------

// File: rtl/fmc_pkg.sv
// Shared types and sizing for the feature-map collector.
// Optional macro: FEATURE_MAP_COLLECTOR_RELU_EN clamps negative pixels to 0 on write.
package fmc_pkg;

    localparam int BitSize            = 4;
    localparam int NumberOfK          = 8;
    localparam int ProcessingElements = 2;
    localparam int MapWidth           = 2;

    localparam int PixPerMap = MapWidth * MapWidth;
    localparam int KIdxW     = $clog2(NumberOfK);
    localparam int PixIdxW   = $clog2(PixPerMap);
    localparam int CntW      = $clog2(PixPerMap + 1);
    localparam int Depth     = NumberOfK * PixPerMap;
    localparam int AddrW     = $clog2(Depth);

    typedef logic [BitSize-1:0] pixel_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    function automatic pixel_t store_pixel(input pixel_t d);
`ifdef FEATURE_MAP_COLLECTOR_RELU_EN
        return d[BitSize-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

endpackage

// File: rtl/fmc_buffer.sv
// Feature-map pixel store: one write port per lane, one registered read port.
// Lanes always address different kernels, so write ports never collide.
module fmc_buffer
    import fmc_pkg::*;
(
    input  logic                          clk,
    input  logic [ProcessingElements-1:0] we,
    input  logic [AddrW-1:0]              waddr [ProcessingElements],
    input  pixel_t                        wdata [ProcessingElements],
    input  logic [AddrW-1:0]              raddr,
    output pixel_t                        rdata
);

    pixel_t mem [Depth];

    // Per-lane writes and a registered read of the requested word
    always_ff @(posedge clk) begin
        for (int l = 0; l < ProcessingElements; l++) begin
            if (we[l]) mem[waddr[l]] <= wdata[l];
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/feature_map_collector.sv
// Collects per-kernel pooled pixels into a buffer, then replays kernel-major.
// Optional macro: FEATURE_MAP_COLLECTOR_RELU_EN (negative pixels stored as 0).
module feature_map_collector
    import fmc_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   res_n,
    input  logic [NumberOfK-1:0]                   in_valid,
    input  logic [ProcessingElements*BitSize-1:0]  in_data,
    output logic                                   in_ready,
    output logic                                   out_valid,
    output logic [BitSize-1:0]                     out_data,
    output logic [KIdxW-1:0]                       out_kernel,
    output logic [PixIdxW-1:0]                     out_pixel,
    input  logic                                   out_ready,
    output logic                                   frame_done,
    output logic                                   err
);

    state_t state, state_next;

    logic [CntW-1:0]               cnt      [NumberOfK];
    logic [CntW-1:0]               cnt_next [NumberOfK];
    logic [ProcessingElements-1:0] we;
    logic [ProcessingElements-1:0] lane_used;
    logic [AddrW-1:0]              waddr [ProcessingElements];
    pixel_t                        wdata [ProcessingElements];
    logic                          collide, overflow, all_full;

    logic [KIdxW-1:0]   rd_k, nk;
    logic [PixIdxW-1:0] rd_p, np;
    logic [AddrW-1:0]   raddr;
    pixel_t             rdata;
    logic               accept, last;

    assign in_ready   = (state == COLLECT);
    assign accept     = out_valid & out_ready;
    assign last       = (rd_k == KIdxW'(NumberOfK - 1)) &&
                        (rd_p == PixIdxW'(PixPerMap - 1));
    assign frame_done = accept & last;
    assign out_data   = out_valid ? rdata : '0;
    assign out_kernel = rd_k;
    assign out_pixel  = rd_p;

    // Lane arbitration: lowest asserted kernel per lane wins, full maps drop
    always_comb begin
        we        = '0;
        lane_used = '0;
        collide   = 1'b0;
        overflow  = 1'b0;
        for (int l = 0; l < ProcessingElements; l++) begin
            waddr[l] = '0;
            wdata[l] = '0;
        end
        for (int k = 0; k < NumberOfK; k++) cnt_next[k] = cnt[k];
        if (state == COLLECT) begin
            for (int k = 0; k < NumberOfK; k++) begin
                if (in_valid[k]) begin
                    if (lane_used[k % ProcessingElements]) begin
                        collide = 1'b1;
                    end else begin
                        lane_used[k % ProcessingElements] = 1'b1;
                        if (cnt[k] == CntW'(PixPerMap)) begin
                            overflow = 1'b1;
                        end else begin
                            we[k % ProcessingElements]    = 1'b1;
                            waddr[k % ProcessingElements] =
                                AddrW'(k * PixPerMap) + AddrW'(cnt[k]);
                            wdata[k % ProcessingElements] = store_pixel(
                                in_data[(k % ProcessingElements) * BitSize +: BitSize]);
                            cnt_next[k] = cnt[k] + 1'b1;
                        end
                    end
                end
            end
        end
        all_full = 1'b1;
        for (int k = 0; k < NumberOfK; k++) begin
            if (cnt_next[k] != CntW'(PixPerMap)) all_full = 1'b0;
        end
    end

    // Next read pointer; addressing it directly keeps one word per cycle
    always_comb begin
        nk = rd_k;
        np = rd_p;
        if (accept) begin
            if (rd_p == PixIdxW'(PixPerMap - 1)) begin
                np = '0;
                nk = last ? '0 : rd_k + 1'b1;
            end else begin
                np = rd_p + 1'b1;
            end
        end
        raddr = AddrW'(int'(nk) * PixPerMap + int'(np));
    end

    // Next-state: fill completes into DRAIN, final accept returns to COLLECT
    always_comb begin
        state_next = state;
        unique case (state)
            COLLECT: if (all_full) state_next = DRAIN;
            DRAIN:   if (accept && last) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (res_n) state <= COLLECT;
        else       state <= state_next;
    end

    // Counters, read pointer, output valid and sticky error
    always_ff @(posedge clk) begin
        if (res_n) begin
            for (int k = 0; k < NumberOfK; k++) cnt[k] <= '0;
            rd_k      <= '0;
            rd_p      <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err  <= err | collide | overflow;
            rd_k <= nk;
            rd_p <= np;
            if (state == COLLECT) begin
                for (int k = 0; k < NumberOfK; k++) cnt[k] <= cnt_next[k];
                out_valid <= 1'b0;
            end else begin
                out_valid <= !(accept && last);
                if (accept && last) begin
                    for (int k = 0; k < NumberOfK; k++) cnt[k] <= '0;
                end
            end
        end
    end

    fmc_buffer u_buffer (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule
